// File: rtl/hi_reader_15_tx_pkg.sv
// Shared types and constants for the ISO15693 reader-to-tag PPM encoder.
//   state_t          : encoder FSM states (IDLE, SOF, DATA, EOF)
//   SLOT_CYCLES_DEF  : default ck_1356meg cycles per PPM slot
//   PAUSE_CYCLES_DEF : default pause width in cycles
//   SLOT_W           : slot counter width (9 bits with the 1-of-256 option, else 3)
//   *_SLOTS / *_PAUSE* : frame-element lengths and pause-slot positions
// Optional feature macro: HI_READER_15_TX_ONE_OF_256_EN.
package hi_reader_15_tx_pkg;

  typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;

  localparam int SLOT_CYCLES_DEF  = 128;
  localparam int PAUSE_CYCLES_DEF = 128;

`ifdef HI_READER_15_TX_ONE_OF_256_EN
  localparam int SLOT_W = 9;
`else
  localparam int SLOT_W = 3;
`endif

  localparam int SOF_SLOTS      = 8;
  localparam int SOF_PAUSE_A    = 0;
  localparam int SOF_PAUSE_B    = 5;
  localparam int SOF256_PAUSE_B = 7;
  localparam int SYM4_SLOTS     = 8;
  localparam int SYM256_SLOTS   = 512;
  localparam int EOF_SLOTS      = 3;
  localparam int EOF_PAUSE      = 1;

endpackage

// File: rtl/hi_reader_15_ppm_tx_if.sv
// Byte interface from the ARM side into the PPM encoder.
//   tx_data  : command byte, sent LSB pair first
//   tx_valid : tx_data/tx_last valid
//   tx_last  : marks the final byte of the frame
//   tx_ready : encoder holding register can take a byte
// Handshake: a byte transfers on every rising clock edge where tx_valid && tx_ready
// are both high; the master holds tx_data/tx_last stable while tx_valid is high and
// not yet accepted, and tx_ready never depends on tx_valid.
interface hi_reader_15_ppm_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/ppm_slot_timer.sv
// PPM slot timing: cycle counter within a slot and slot counter within a symbol.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_run             : counters advance only while high
//   i_last_slot       : index of the final slot of the current symbol
//   i_pause_a/_b      : slots that carry a pause (set equal for a single pause)
//   o_symbol_end      : high on the last cycle of the symbol's last slot
//   o_pause           : current cycle lies inside a pause window
module ppm_slot_timer
  import hi_reader_15_tx_pkg::*;
#(
  parameter int SLOT_CYCLES  = SLOT_CYCLES_DEF,
  parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF,
  parameter int SW           = SLOT_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic [SW-1:0] i_last_slot,
  input  logic [SW-1:0] i_pause_a,
  input  logic [SW-1:0] i_pause_b,
  output logic          o_symbol_end,
  output logic          o_pause
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  // One extra bit so a pause as long as the whole slot is representable.
  localparam logic [CW:0]   PAUSE_LEN = (CW + 1)'(PAUSE_CYCLES);

  logic [CW-1:0] r_cyc;
  logic [SW-1:0] r_slot;
  logic          w_slot_end;

  assign w_slot_end   = i_run && (r_cyc == CYC_LAST);
  assign o_symbol_end = w_slot_end && (r_slot == i_last_slot);
  assign o_pause      = i_run && ((r_slot == i_pause_a) || (r_slot == i_pause_b)) &&
                        ({1'b0, r_cyc} < PAUSE_LEN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc  <= '0;
      r_slot <= '0;
    end else if (i_run) begin
      if (w_slot_end) r_cyc <= '0;
      else            r_cyc <= r_cyc + CW'(1);
      if (o_symbol_end)    r_slot <= '0;
      else if (w_slot_end) r_slot <= r_slot + SW'(1);
    end
  end

endmodule

// File: rtl/hi_reader_15_ppm_tx.sv
// ISO15693 reader-to-tag encoder: SOF, 1-of-4 PPM data, EOF as a carrier-pause
// envelope. The top level gates the carrier with pwr_hi = ck_1356meg & ~mod_out.
//   ck_1356meg   : 13.56 MHz clock
//   reset        : synchronous, active-high
//   mode_256     : 1-of-256 select, sampled at frame start (only with
//                  HI_READER_15_TX_ONE_OF_256_EN defined)
//   tx           : byte interface (slave modport)
//   mod_out      : 1 = carrier pause (registered)
//   busy         : high from SOF start through the done cycle
//   done         : one-cycle pulse on the final cycle of EOF
//   err_underrun : sticky, set when the byte stream ran dry before tx_last
//   dbg_state    : current FSM state
// All registered outputs share one cycle of latency relative to the FSM state,
// so mod_out, busy and done stay aligned with each other.
module hi_reader_15_ppm_tx
  import hi_reader_15_tx_pkg::*;
#(
  parameter int SLOT_CYCLES  = SLOT_CYCLES_DEF,
  parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
  input  logic                 ck_1356meg,
  input  logic                 reset,
`ifdef HI_READER_15_TX_ONE_OF_256_EN
  input  logic                 mode_256,
`endif
  hi_reader_15_ppm_tx_if.slave tx,
  output logic                 mod_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_underrun,
  output state_t               dbg_state
);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_hold, r_shift;
  logic            r_hold_full, r_hold_last, r_cur_last;
  logic [1:0]      r_pair;
  logic            r_mod, r_busy, r_done, r_err;
  logic            w_mode256;
  logic            w_run, w_sym_end, w_pause;
  logic [SLOT_W-1:0] w_last_slot, w_pause_a, w_pause_b;
  logic            w_ready, w_accept, w_byte_end, w_reload, w_underrun;

`ifdef HI_READER_15_TX_ONE_OF_256_EN
  logic r_mode256;
  assign w_mode256 = r_mode256;
`else
  assign w_mode256 = 1'b0;
`endif

  // Bytes after the frame's last byte wait until the frame has finished.
  assign w_ready    = !r_hold_full && (r_state != EOF) && !((r_state == DATA) && r_cur_last);
  assign tx.tx_ready = w_ready;
  assign w_accept   = tx.tx_valid && w_ready;
  assign w_run      = (r_state != IDLE);
  assign w_byte_end = w_mode256 || (r_pair == 2'd3);
  // SOF end always loads the first byte; later loads chain bytes with no gap.
  assign w_reload   = w_sym_end && ((r_state == SOF) ||
                      ((r_state == DATA) && w_byte_end && !r_cur_last && r_hold_full));
  assign w_underrun = w_sym_end && (r_state == DATA) && w_byte_end && !r_cur_last && !r_hold_full;

  ppm_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .PAUSE_CYCLES (PAUSE_CYCLES),
    .SW           (SLOT_W)
  ) u_timer (
    .i_clk        (ck_1356meg),
    .i_rst        (reset),
    .i_run        (w_run),
    .i_last_slot  (w_last_slot),
    .i_pause_a    (w_pause_a),
    .i_pause_b    (w_pause_b),
    .o_symbol_end (w_sym_end),
    .o_pause      (w_pause)
  );

  // Symbol length and pause positions for the element being sent.
  always_comb begin
    w_last_slot = '0;
    w_pause_a   = '0;
    w_pause_b   = '0;
    case (r_state)
      SOF: begin
        w_last_slot = SLOT_W'(SOF_SLOTS - 1);
        w_pause_a   = SLOT_W'(SOF_PAUSE_A);
        w_pause_b   = w_mode256 ? SLOT_W'(SOF256_PAUSE_B) : SLOT_W'(SOF_PAUSE_B);
      end
      DATA: begin
`ifdef HI_READER_15_TX_ONE_OF_256_EN
        if (w_mode256) begin
          w_last_slot = SLOT_W'(SYM256_SLOTS - 1);
          w_pause_a   = {r_shift, 1'b1};
        end else begin
          w_last_slot = SLOT_W'(SYM4_SLOTS - 1);
          w_pause_a   = SLOT_W'({r_shift[1:0], 1'b1});
        end
`else
        w_last_slot = SLOT_W'(SYM4_SLOTS - 1);
        w_pause_a   = {r_shift[1:0], 1'b1};
`endif
        w_pause_b   = w_pause_a;
      end
      EOF: begin
        w_last_slot = SLOT_W'(EOF_SLOTS - 1);
        w_pause_a   = SLOT_W'(EOF_PAUSE);
        w_pause_b   = SLOT_W'(EOF_PAUSE);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = SOF;
      SOF:  if (w_sym_end) w_state_nxt = DATA;
      // Byte finished without a follow-on byte: tx_last seen or underrun.
      DATA: if (w_sym_end && w_byte_end && !w_reload) w_state_nxt = EOF;
      EOF:  if (w_sym_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_shift     <= '0;
      r_cur_last  <= 1'b0;
      r_pair      <= '0;
      r_mod       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef HI_READER_15_TX_ONE_OF_256_EN
      r_mode256   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_hold      <= tx.tx_data;
        r_hold_last <= tx.tx_last;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end

      if (w_reload) begin
        r_shift    <= r_hold;
        r_cur_last <= r_hold_last;
        r_pair     <= '0;
      end else if ((r_state == DATA) && w_sym_end) begin
        r_shift <= r_shift >> 2;
        r_pair  <= r_pair + 2'd1;
      end

      if ((r_state == IDLE) && w_accept) begin
        r_err <= 1'b0;
`ifdef HI_READER_15_TX_ONE_OF_256_EN
        r_mode256 <= mode_256;
`endif
      end else if (w_underrun) begin
        r_err <= 1'b1;
      end

      r_mod  <= w_pause;
      r_busy <= w_run;
      r_done <= (r_state == EOF) && w_sym_end;
    end
  end

  assign mod_out      = r_mod;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_underrun = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_hi_reader_15_ppm_tx.sv
// Directed bench for hi_reader_15_ppm_tx: single byte, back-to-back bytes,
// underrun, mid-frame reset, narrow pause width, and (with
// HI_READER_15_TX_ONE_OF_256_EN) 1-of-256 mode. Expected pause offsets are
// hand-computed from the slot timing (128 cycles per slot).
module tb_hi_reader_15_ppm_tx;
  import hi_reader_15_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef HI_READER_15_TX_ONE_OF_256_EN
  logic mode_256   = 1'b0;
  logic mode_256_b = 1'b0;
`endif

  hi_reader_15_ppm_tx_if bus0();
  hi_reader_15_ppm_tx_if bus1();

  logic   mod0, busy0, done0, err0;
  logic   mod1, busy1, done1, err1;
  state_t dbg0, dbg1;

  hi_reader_15_ppm_tx dut0 (
    .ck_1356meg   (clk),
    .reset        (reset),
`ifdef HI_READER_15_TX_ONE_OF_256_EN
    .mode_256     (mode_256),
`endif
    .tx           (bus0),
    .mod_out      (mod0),
    .busy         (busy0),
    .done         (done0),
    .err_underrun (err0),
    .dbg_state    (dbg0)
  );

  hi_reader_15_ppm_tx #(.PAUSE_CYCLES(32)) dut1 (
    .ck_1356meg   (clk),
    .reset        (reset),
`ifdef HI_READER_15_TX_ONE_OF_256_EN
    .mode_256     (mode_256_b),
`endif
    .tx           (bus1),
    .mod_out      (mod1),
    .busy         (busy1),
    .done         (done1),
    .err_underrun (err1),
    .dbg_state    (dbg1)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          rise_q[$];
  int          width_q[$];
  int          done_off, done_cnt, busy_fall_off, err_first_off;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] data, input logic last, input int limit);
    bit rdy;
    int n;
    if (sel) begin
      bus1.tx_data = data; bus1.tx_last = last; bus1.tx_valid = 1'b1;
    end else begin
      bus0.tx_data = data; bus0.tx_last = last; bus0.tx_valid = 1'b1;
    end
    n = 0;
    rdy = sel ? bus1.tx_ready : bus0.tx_ready;
    while (!rdy && n < limit) begin
      step();
      n++;
      rdy = sel ? bus1.tx_ready : bus0.tx_ready;
    end
    n_tests++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL send_ready: tx_ready got 0 required 1 within %0d cycles", limit);
    end
    step();
    if (sel) bus1.tx_valid = 1'b0;
    else     bus0.tx_valid = 1'b0;
  endtask

  // Records pause rises/widths, done and err timing relative to the first rise.
  task automatic capture(input bit sel, input int max_cyc);
    bit m, b, d, e, prev_mod, prev_busy;
    int t0, rise_t;
    rise_q.delete();
    width_q.delete();
    done_off = -1; done_cnt = 0; busy_fall_off = -1; err_first_off = -1;
    t0 = -1; rise_t = 0; prev_mod = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      m = sel ? mod1 : mod0;
      b = sel ? busy1 : busy0;
      d = sel ? done1 : done0;
      e = sel ? err1 : err0;
      if (m && !prev_mod) begin
        if (t0 < 0) t0 = i;
        rise_t = i;
        rise_q.push_back(i - t0);
      end
      if (!m && prev_mod) width_q.push_back(i - rise_t);
      if (d) begin
        done_cnt++;
        if (done_off < 0) done_off = i - t0;
      end
      if (e && err_first_off < 0) err_first_off = i - t0;
      if (!b && prev_busy) begin
        busy_fall_off = i - t0;
        break;
      end
      prev_mod = m;
      prev_busy = b;
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++; if (mod0 !== 1'b0) begin n_fail++; $display("FAIL reset_mod: got %b required 0", mod0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy0); end
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done0); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err0); end
    n_tests++; if (bus0.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus0.tx_ready); end
    n_tests++; if (bus1.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b required 1", bus1.tx_ready); end
    n_tests++; if (dbg0 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg0, IDLE); end
  endtask

  task automatic test_single_byte();
    int ev[7] = '{0, 640, 1920, 2688, 3456, 4224, 5248};
    int got;
    send_byte(1'b0, 8'h1B, 1'b1, 10);
    capture(1'b0, 7000);
    exp_q.delete();
    foreach (ev[k]) exp_q.push_back(ev[k]);
    n_tests++;
    if (rise_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_npause: got %0d required %0d", rise_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rise_q.size()) ? rise_q[k] : -1;
      n_tests++;
      if (got !== int'(exp_q[k])) begin n_fail++; $display("FAIL single_rise%0d: got %0d required %0d", k, got, exp_q[k]); end
    end
    for (int k = 0; k < width_q.size(); k++) begin
      n_tests++;
      if (width_q[k] !== 128) begin n_fail++; $display("FAIL single_width%0d: got %0d required 128", k, width_q[k]); end
    end
    n_tests++; if (done_off !== 5503) begin n_fail++; $display("FAIL single_done: got %0d required 5503", done_off); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d required 1", done_cnt); end
    n_tests++; if (busy_fall_off !== 5504) begin n_fail++; $display("FAIL single_busy_fall: got %0d required 5504", busy_fall_off); end
    n_tests++; if (err_first_off !== -1) begin n_fail++; $display("FAIL single_err: got %0d required -1", err_first_off); end
  endtask

  task automatic test_back_to_back();
    int ev[11] = '{0, 640, 1152, 2176, 3200, 4224, 6016, 7040, 8064, 9088, 9344};
    int got;
    send_byte(1'b0, 8'h00, 1'b0, 10);
    fork
      capture(1'b0, 11000);
      send_byte(1'b0, 8'hFF, 1'b1, 3000);
    join
    exp_q.delete();
    foreach (ev[k]) exp_q.push_back(ev[k]);
    n_tests++;
    if (rise_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_npause: got %0d required %0d", rise_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rise_q.size()) ? rise_q[k] : -1;
      n_tests++;
      if (got !== int'(exp_q[k])) begin n_fail++; $display("FAIL b2b_rise%0d: got %0d required %0d", k, got, exp_q[k]); end
    end
    n_tests++; if (done_off !== 9599) begin n_fail++; $display("FAIL b2b_done: got %0d required 9599", done_off); end
    n_tests++; if (err_first_off !== -1) begin n_fail++; $display("FAIL b2b_err: got %0d required -1", err_first_off); end
  endtask

  task automatic test_underrun();
    int ev[7] = '{0, 640, 1152, 2176, 3200, 4224, 5248};
    int got;
    send_byte(1'b0, 8'h00, 1'b0, 10);
    capture(1'b0, 7000);
    exp_q.delete();
    foreach (ev[k]) exp_q.push_back(ev[k]);
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rise_q.size()) ? rise_q[k] : -1;
      n_tests++;
      if (got !== int'(exp_q[k])) begin n_fail++; $display("FAIL under_rise%0d: got %0d required %0d", k, got, exp_q[k]); end
    end
    n_tests++;
    if (err_first_off < 5119 || err_first_off > 5120) begin
      n_fail++; $display("FAIL under_err_time: got %0d required 5119..5120", err_first_off);
    end
    n_tests++; if (done_off !== 5503) begin n_fail++; $display("FAIL under_done: got %0d required 5503", done_off); end
    for (int k = 0; k < 20; k++) step();
    n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL under_err_sticky: got %b required 1", err0); end
    send_byte(1'b0, 8'h1B, 1'b1, 10);
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL under_err_clear: got %b required 0", err0); end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    int n, dones, mods;
    send_byte(1'b0, 8'h1B, 1'b1, 10);
    n = 0;
    while (!mod0 && n < 10) begin step(); n++; end
    n_tests++; if (mod0 !== 1'b1) begin n_fail++; $display("FAIL midrst_start: mod_out got %b required 1", mod0); end
    for (int k = 0; k < 2000; k++) step();
    n_tests++; if (mod0 !== 1'b1) begin n_fail++; $display("FAIL midrst_inpause: mod_out got %b required 1", mod0); end
    reset = 1'b1;
    step();
    n_tests++; if (mod0 !== 1'b0) begin n_fail++; $display("FAIL midrst_mod: got %b required 0", mod0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy0); end
    n_tests++; if (bus0.tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus0.tx_ready); end
    reset = 1'b0;
    dones = 0; mods = 0;
    for (int k = 0; k < 300; k++) begin
      if (done0) dones++;
      if (mod0) mods++;
      step();
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d required 0", dones); end
    n_tests++; if (mods !== 0) begin n_fail++; $display("FAIL midrst_no_mod: got %0d required 0", mods); end
  endtask

  task automatic test_pause32();
    int ev[7] = '{0, 640, 1920, 2688, 3456, 4224, 5248};
    int got;
    send_byte(1'b1, 8'h1B, 1'b1, 10);
    capture(1'b1, 7000);
    exp_q.delete();
    foreach (ev[k]) exp_q.push_back(ev[k]);
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rise_q.size()) ? rise_q[k] : -1;
      n_tests++;
      if (got !== int'(exp_q[k])) begin n_fail++; $display("FAIL p32_rise%0d: got %0d required %0d", k, got, exp_q[k]); end
    end
    n_tests++;
    if (width_q.size() != 7) begin n_fail++; $display("FAIL p32_nwidth: got %0d required 7", width_q.size()); end
    for (int k = 0; k < width_q.size(); k++) begin
      n_tests++;
      if (width_q[k] !== 32) begin n_fail++; $display("FAIL p32_width%0d: got %0d required 32", k, width_q[k]); end
    end
    n_tests++; if (done_off !== 5503) begin n_fail++; $display("FAIL p32_done: got %0d required 5503", done_off); end
  endtask

`ifdef HI_READER_15_TX_ONE_OF_256_EN
  task automatic test_mode256();
    int ev[4] = '{0, 896, 1920, 66688};
    int got;
    mode_256 = 1'b1;
    send_byte(1'b0, 8'h03, 1'b1, 10);
    mode_256 = 1'b0;
    capture(1'b0, 70000);
    exp_q.delete();
    foreach (ev[k]) exp_q.push_back(ev[k]);
    n_tests++;
    if (rise_q.size() != exp_q.size()) begin n_fail++; $display("FAIL m256_npause: got %0d required %0d", rise_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rise_q.size()) ? rise_q[k] : -1;
      n_tests++;
      if (got !== int'(exp_q[k])) begin n_fail++; $display("FAIL m256_rise%0d: got %0d required %0d", k, got, exp_q[k]); end
    end
    n_tests++; if (done_off !== 66943) begin n_fail++; $display("FAIL m256_done: got %0d required 66943", done_off); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus0.tx_data = '0; bus0.tx_valid = 1'b0; bus0.tx_last = 1'b0;
    bus1.tx_data = '0; bus1.tx_valid = 1'b0; bus1.tx_last = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_pause32();
`ifdef HI_READER_15_TX_ONE_OF_256_EN
    test_mode256();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
